// File: rtl/dpll_loop_ctrl.sv
// Phase-detect and loop-control sequencer for the all-digital PLL.
// Measures the signed ref/DCO phase error and steps the DCO divider until lock.
module dpll_loop_ctrl #(
    parameter int ERR_W      = 16,
    parameter int MAX_WIN    = 255,
    parameter int LOCK_TOL   = 2,
    parameter int UNLOCK_TOL = 6,
    parameter int LOCK_CNT   = 8,
    parameter int PHASE_OFS  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             ref_in,
    input  logic             dco_clk,
    output logic             add,
    output logic             plus,
    output logic             bothedge,
    output logic             locked,
    output logic [1:0]       state,
    output logic [ERR_W-1:0] phase_err
);
    localparam int CNT_W = $clog2(MAX_WIN + 1);
    localparam int LCK_W = $clog2(LOCK_CNT + 1);
    localparam logic signed [ERR_W-1:0] LOCK_TOL_S   = ERR_W'(LOCK_TOL);
    localparam logic signed [ERR_W-1:0] UNLOCK_TOL_S = ERR_W'(UNLOCK_TOL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ACQ   = 2'd2,
        LOCK  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic ref_s1, ref_s2, ref_d;
    logic dco_s1, dco_s2, dco_d;
    logic ref_ev, dco_ev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_s1 <= 1'b0;
            ref_s2 <= 1'b0;
            ref_d  <= 1'b0;
            dco_s1 <= 1'b0;
            dco_s2 <= 1'b0;
            dco_d  <= 1'b0;
        end else begin
            ref_s1 <= ref_in;
            ref_s2 <= ref_s1;
            ref_d  <= ref_s2;
            dco_s1 <= dco_clk;
            dco_s2 <= dco_s1;
            dco_d  <= dco_s2;
        end
    end

    assign ref_ev = ref_s2 & ~ref_d;
    assign dco_ev = ~dco_s2 & dco_d;

    logic              active;
    logic              win_open_q, win_open_d;
    logic              lead_ref_q, lead_ref_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lag_ev, lead_ev;
    logic              meas_done, timeout;
    logic [ERR_W-1:0]  cnt_ext, raw;
    logic              done_q;
    logic [ERR_W-1:0]  err_q;

    assign active = enable && (state_q == ACQ || state_q == LOCK);

    // Raw magnitude counts the completion cycle too, so cnt_q + 1 is the distance
    // between events; timeout fires on the edge where that distance hits MAX_WIN.
    always_comb begin
        win_open_d = win_open_q;
        lead_ref_d = lead_ref_q;
        cnt_d      = cnt_q;
        meas_done  = 1'b0;
        timeout    = 1'b0;
        lag_ev     = lead_ref_q ? dco_ev : ref_ev;
        lead_ev    = lead_ref_q ? ref_ev : dco_ev;
        cnt_ext    = ERR_W'(cnt_q) + ERR_W'(1);
        raw        = '0;
        if (!active) begin
            win_open_d = 1'b0;
            lead_ref_d = 1'b0;
            cnt_d      = '0;
        end else if (!win_open_q) begin
            if (ref_ev && dco_ev) begin
                meas_done = 1'b1;
            end else if (ref_ev || dco_ev) begin
                win_open_d = 1'b1;
                lead_ref_d = ref_ev;
                cnt_d      = '0;
            end
        end else if (lag_ev) begin
            meas_done  = 1'b1;
            win_open_d = 1'b0;
            raw        = lead_ref_q ? cnt_ext : -cnt_ext;
        end else if (lead_ev) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(MAX_WIN - 1)) begin
            timeout    = 1'b1;
            win_open_d = 1'b0;
            cnt_d      = CNT_W'(MAX_WIN);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_open_q <= 1'b0;
            lead_ref_q <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            win_open_q <= win_open_d;
            lead_ref_q <= lead_ref_d;
            cnt_q      <= cnt_d;
            done_q     <= meas_done;
            if (meas_done)
                err_q <= raw - ERR_W'(PHASE_OFS);
        end
    end

    logic signed [ERR_W-1:0] err_s;
    logic                    in_tol, out_unlock;
    logic [LCK_W-1:0]        lock_q, lock_d;
    logic                    add_d, plus_d, both_d;

    assign err_s      = err_q;
    assign in_tol     = (err_s <= LOCK_TOL_S) && (err_s >= -LOCK_TOL_S);
    assign out_unlock = (err_s > UNLOCK_TOL_S) || (err_s < -UNLOCK_TOL_S);

    // Decisions act on the registered error, so pulses land one cycle after phase_err.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        add_d   = 1'b0;
        plus_d  = 1'b0;
        both_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            lock_d  = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ALIGN;
                ALIGN: begin
                    lock_d = '0;
                    if (ref_ev) begin
                        both_d  = 1'b1;
                        state_d = ACQ;
                    end
                end
                ACQ: begin
                    if (timeout) begin
                        state_d = ALIGN;
                        lock_d  = '0;
                    end else if (done_q) begin
                        if (in_tol) begin
                            if (lock_q >= LCK_W'(LOCK_CNT - 1)) begin
                                lock_d  = LCK_W'(LOCK_CNT);
                                state_d = LOCK;
                            end else begin
                                lock_d = lock_q + LCK_W'(1);
                            end
                        end else begin
                            lock_d = '0;
                            plus_d = ~err_s[ERR_W-1];
                            add_d  = err_s[ERR_W-1];
                        end
                    end
                end
                LOCK: begin
                    if (timeout) begin
                        state_d = ALIGN;
                    end else if (done_q && !in_tol) begin
                        if (out_unlock) begin
                            state_d = ALIGN;
                        end else begin
                            plus_d = ~err_s[ERR_W-1];
                            add_d  = err_s[ERR_W-1];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            lock_q   <= '0;
            add      <= 1'b0;
            plus     <= 1'b0;
            bothedge <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            add      <= add_d;
            plus     <= plus_d;
            bothedge <= both_d;
            locked   <= (state_d == LOCK);
        end
    end

    assign state     = state_q;
    assign phase_err = err_q;

endmodule
